// File: rtl/ov7670_camera_configure.sv
// OV7670 power-up register loader: walks a fixed ROM and writes each entry as a 3-phase SCCB write.
// Optional build macro CAM_CFG_SOFT_RESET_EN prepends a COM7 soft reset and a settle delay.
module ov7670_camera_configure #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned SCCB_FREQ = 100_000,
    parameter logic [7:0]  CAM_ID    = 8'h42,
    parameter int unsigned DELAY_MS  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic sioc,
    output logic siod,
    output logic done
);

    localparam int unsigned QUARTER = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int unsigned HALF    = 2 * QUARTER;
    localparam int unsigned BITLEN  = 4 * QUARTER;
    localparam longint unsigned DELAY_CYC64 = (64'(DELAY_MS) * 64'(CLK_FREQ)) / 64'd1000;
    localparam int unsigned DELAY_CYC = 32'(DELAY_CYC64);
    localparam logic [15:0] ENT_END = 16'hFFFF;
    localparam logic [15:0] ENT_DLY = 16'hFFF0;
    localparam logic [4:0]  LAST_BIT = 5'd26;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SEND, S_STOP, S_GAP, S_FETCH, S_DELAY, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt;
    logic [4:0]  bitn;
    logic [3:0]  idx;
    logic [15:0] cur;
    logic [15:0] rom_q;
    logic [26:0] frame;
    logic        sioc_d, siod_d, done_d;
    logic        launch;

    // Register table, read sequentially from index 0 until the end marker.
    function automatic logic [15:0] rom(input logic [3:0] a);
`ifdef CAM_CFG_SOFT_RESET_EN
        case (a)
            4'd0:    rom = 16'h1280;
            4'd1:    rom = ENT_DLY;
            4'd2:    rom = 16'h1204;
            4'd3:    rom = 16'h1180;
            4'd4:    rom = 16'h0C00;
            4'd5:    rom = 16'h3E00;
            4'd6:    rom = 16'h0400;
            4'd7:    rom = 16'h40D0;
            4'd8:    rom = 16'h3A04;
            4'd9:    rom = 16'h1418;
            default: rom = ENT_END;
        endcase
`else
        case (a)
            4'd0:    rom = 16'h1204;
            4'd1:    rom = 16'h1180;
            4'd2:    rom = 16'h0C00;
            4'd3:    rom = 16'h3E00;
            4'd4:    rom = 16'h0400;
            4'd5:    rom = 16'h40D0;
            4'd6:    rom = 16'h3A04;
            4'd7:    rom = 16'h1418;
            default: rom = ENT_END;
        endcase
`endif
    endfunction

    assign rom_q  = rom(idx);
    assign frame  = {CAM_ID, 1'b1, cur[15:8], 1'b1, cur[7:0], 1'b1};
    assign launch = ((state == S_IDLE) || (state == S_DONE)) && start;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            sioc  <= 1'b1;
            siod  <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            sioc  <= sioc_d;
            siod  <= siod_d;
            done  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_START;
            S_START: if (cnt == HALF - 1) state_nxt = S_SEND;
            S_SEND:  if ((cnt == BITLEN - 1) && (bitn == LAST_BIT)) state_nxt = S_STOP;
            S_STOP:  if (cnt == HALF - 1) state_nxt = S_GAP;
            S_GAP:   if (cnt == BITLEN - 1) state_nxt = S_FETCH;
            S_FETCH: begin
                if (rom_q == ENT_END)      state_nxt = S_DONE;
                else if (rom_q == ENT_DLY) state_nxt = S_DELAY;
                else                       state_nxt = S_START;
            end
            S_DELAY: if ((33'(cnt) + 33'd1) >= 33'(DELAY_CYC)) state_nxt = S_FETCH;
            S_DONE:  if (start) state_nxt = S_START;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus waveform; done follows the next state so it clears on the restart edge.
    always_comb begin
        sioc_d = 1'b1;
        siod_d = 1'b1;
        done_d = (state_nxt == S_DONE);
        case (state)
            S_START: siod_d = (cnt < QUARTER);
            S_SEND: begin
                sioc_d = (cnt >= HALF);
                siod_d = frame[LAST_BIT - bitn];
            end
            S_STOP: begin
                sioc_d = (cnt >= QUARTER);
                siod_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Phase counter, bit counter and table pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            bitn <= '0;
            idx  <= '0;
            cur  <= '0;
        end else begin
            if ((state_nxt != state) || (state == S_IDLE) || (state == S_DONE))
                cnt <= '0;
            else if ((state == S_SEND) && (cnt == BITLEN - 1))
                cnt <= '0;
            else
                cnt <= cnt + 32'd1;

            if ((state != S_SEND) || (state_nxt != S_SEND))
                bitn <= '0;
            else if (cnt == BITLEN - 1)
                bitn <= bitn + 5'd1;

            if (launch) begin
                cur <= rom(4'd0);
                idx <= 4'd1;
            end else if ((state == S_FETCH) && (rom_q != ENT_END)) begin
                cur <= rom_q;
                idx <= idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_camera_configure.sv
// Randomized bench for ov7670_camera_configure: decodes the SCCB bus and scores it against the register table.
module tb_ov7670_camera_configure;

    localparam int unsigned CLK_FREQ  = 4_000_000;
    localparam int unsigned SCCB_FREQ = 100_000;
    localparam int unsigned DELAY_MS  = 1;
    localparam logic [7:0]  CAM_ID    = 8'h42;
    localparam int Q         = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int DELAY_CYC = DELAY_MS * (CLK_FREQ / 1000);
`ifdef CAM_CFG_SOFT_RESET_EN
    localparam int NTXN = 9;
`else
    localparam int NTXN = 8;
`endif
    localparam logic [15:0] TBL [8] = '{16'h1204, 16'h1180, 16'h0C00, 16'h3E00,
                                        16'h0400, 16'h40D0, 16'h3A04, 16'h1418};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic sioc, siod, done;

    always #5 clk = ~clk;

    ov7670_camera_configure #(
        .CLK_FREQ(CLK_FREQ), .SCCB_FREQ(SCCB_FREQ), .CAM_ID(CAM_ID), .DELAY_MS(DELAY_MS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .sioc(sioc), .siod(siod), .done(done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] v;
        logic       dly;
    } txn_t;

    txn_t expq[$];

    // Expected writes for one replay of the table.
    task automatic load_table();
        logic [15:0] w;
        logic        first_dly;
        expq.delete();
        first_dly = 1'b0;
`ifdef CAM_CFG_SOFT_RESET_EN
        expq.push_back({8'h12, 8'h80, 1'b0});
        first_dly = 1'b1;
`endif
        for (int i = 0; i < 8; i++) begin
            w = TBL[i];
            expq.push_back({w[15:8], w[7:0], (i == 0) ? first_dly : 1'b0});
        end
    endtask

    // Bus decoder, sampled on the falling clock edge.
    int   cyc = 0, last_edge = 0, last_stop = 0, nbits = 0, ntxn = 0, nchg = 0;
    logic in_txn = 1'b0, ps = 1'b1, pd = 1'b1, pdone = 1'b0;
    logic [26:0] sh = '0;
    txn_t e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            in_txn = 1'b0;
            nbits  = 0;
        end else begin
            if (ps && sioc && (siod !== pd)) begin
                if (!siod) begin
                    check("start_while_busy", longint'(in_txn), 0);
                    in_txn = 1'b1;
                    nbits  = 0;
                    sh     = '0;
                    if (expq.size() > 0 && expq[0].dly)
                        check("delay_gap", longint'(cyc - last_stop >= DELAY_CYC), 1);
                end else begin
                    check("stop_bits", nbits, 27);
                    if (in_txn && nbits == 27) begin
                        if (expq.size() == 0) begin
                            check("extra_txn", 1, 0);
                        end else begin
                            e = expq.pop_front();
                            check("cam_id", sh[26:19], CAM_ID);
                            check("reg", sh[17:10], e.r);
                            check("val", sh[8:1], e.v);
                            check("dontcare_bits", {sh[18], sh[9], sh[0]}, 3'b111);
                        end
                        ntxn++;
                    end
                    in_txn    = 1'b0;
                    last_stop = cyc;
                end
            end
            if (!ps && sioc && in_txn && nbits < 27) begin
                check("sioc_low_len", cyc - last_edge, 2 * Q);
                sh = {sh[25:0], siod};
                nbits++;
            end
            if (ps && !sioc && in_txn && nbits >= 1)
                check("sioc_high_len", cyc - last_edge, 2 * Q);
            if (done && !pdone)
                check("done_latency_ok",
                      longint'((cyc - last_stop >= 4 * Q) && (cyc - last_stop <= 4 * Q + 2)), 1);
        end
        if (sioc !== ps || siod !== pd) nchg++;
        if (sioc !== ps) last_edge = cyc;
        ps    = sioc;
        pd    = siod;
        pdone = done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int g;
        g = 0;
        while (!done && g < limit) begin
            tick(1);
            g++;
        end
        check("done_timeout", longint'(done), 1);
    endtask

    // One complete table run with ignored start pulses sprinkled in.
    task automatic full_run(input int nbusy);
        int base;
        base = ntxn;
        load_table();
        pulse_start();
        for (int i = 0; i < nbusy; i++) begin
            tick($urandom_range(100, 2000));
            pulse_start();
        end
        wait_done(30000);
        check("txn_count", ntxn - base, NTXN);
        check("expq_drained", expq.size(), 0);
        tick($urandom_range(20, 80));
        @(negedge clk);
        check("done_held", longint'(done), 1);
        check("idle_bus", {sioc, siod}, 2'b11);
        tick(1);
    endtask

    initial begin
        int k, base, tgt, g;

        tick(3);
        @(negedge clk);
        check("rst_sioc", longint'(sioc), 1);
        check("rst_siod", longint'(siod), 1);
        check("rst_done", longint'(done), 0);
        tick(1);
        reset = 1'b0;
        base = nchg;
        tick(1000);
        @(negedge clk);
        check("idle_quiet", nchg - base, 0);
        check("idle_done", longint'(done), 0);
        tick(1);

        // First run: start latency, then the rest of the table.
        base = ntxn;
        load_table();
        pulse_start();
        k = 0;
        @(negedge clk);
        while (siod === 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("start_latency", k, Q + 1);
        check("start_sioc_high", longint'(sioc), 1);
        tick(1);
        for (int i = 0; i < 2; i++) begin
            tick($urandom_range(100, 2000));
            pulse_start();
        end
        wait_done(30000);
        check("txn_count", ntxn - base, NTXN);
        check("expq_drained", expq.size(), 0);
        tick(1);

        // Restart from DONE, then reset mid-byte.
        load_table();
        pulse_start();
        @(negedge clk);
        check("done_clear", longint'(done), 0);
        tick(1);
        tgt = 12;
        g = 0;
        while (nbits != tgt && g < 5000) begin
            tick(1);
            g++;
        end
        check("reached_bit", nbits, tgt);
        tick($urandom_range(0, 3 * Q));
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        check("midrst_sioc", longint'(sioc), 1);
        check("midrst_siod", longint'(siod), 1);
        check("midrst_done", longint'(done), 0);
        tick(2);
        reset = 1'b0;
        tick($urandom_range(5, 50));

        full_run(int'($urandom_range(0, 3)));

        // Replay after done, with a random mid-byte reset first.
        load_table();
        pulse_start();
        tgt = int'($urandom_range(2, 25));
        g = 0;
        while (nbits != tgt && g < 5000) begin
            tick(1);
            g++;
        end
        check("reached_bit_rand", nbits, tgt);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        check("midrst2_bus", {sioc, siod, done}, 3'b110);
        tick(2);
        reset = 1'b0;
        tick(1);

        full_run(int'($urandom_range(1, 3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
